// File: rtl/issue_window_if.sv
// Handshake and bus bundle for the issue window.
// master drives enqueue/wakeup/flush/accept; slave is the window.
interface issue_window_if #(
  parameter int ID_W      = 3,
  parameter int NUM_WB    = 2,
  parameter int PTAG_W    = 6,
  parameter int CTX_W     = 4,
  parameter int PAYLOAD_W = 64
) ();
  logic                     enq_valid;
  logic                     enq_ready;
  logic [PTAG_W-1:0]        enq_rs1_tag;
  logic                     enq_rs1_rdy;
  logic [PTAG_W-1:0]        enq_rs2_tag;
  logic                     enq_rs2_rdy;
  logic [CTX_W-1:0]         enq_ctx;
  logic [PAYLOAD_W-1:0]     enq_payload;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*PTAG_W-1:0] wb_tag;
  logic                     flush;
  logic [CTX_W-1:0]         flush_mask;
  logic                     iss_valid;
  logic                     iss_accepted;
  logic [PAYLOAD_W-1:0]     iss_payload;
  logic [CTX_W-1:0]         iss_ctx;
  logic [ID_W:0]            count;

  modport master (
    output enq_valid, enq_rs1_tag, enq_rs1_rdy,
    output enq_rs2_tag, enq_rs2_rdy, enq_ctx,
    output enq_payload, wb_valid, wb_tag,
    output flush, flush_mask, iss_accepted,
    input  enq_ready, iss_valid, iss_payload,
    input  iss_ctx, count
  );

  modport slave (
    input  enq_valid, enq_rs1_tag, enq_rs1_rdy,
    input  enq_rs2_tag, enq_rs2_rdy, enq_ctx,
    input  enq_payload, wb_valid, wb_tag,
    input  flush, flush_mask, iss_accepted,
    output enq_ready, iss_valid, iss_payload,
    output iss_ctx, count
  );
endinterface

// File: rtl/issue_window.sv
// Age-ordered, self-compacting issue window with tag wakeup,
// oldest-ready selection over the first SCAN slots and context flush.
module issue_window #(
  parameter int DEPTH     = 8,
  parameter int ID_W      = 3,
  parameter int SCAN      = 4,
  parameter int NUM_WB    = 2,
  parameter int PTAG_W    = 6,
  parameter int CTX_W     = 4,
  parameter int PAYLOAD_W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  issue_window_if.slave io
);

  localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);

  typedef struct packed {
    logic                 vld;
    logic                 r1;
    logic [PTAG_W-1:0]    t1;
    logic                 r2;
    logic [PTAG_W-1:0]    t2;
    logic [CTX_W-1:0]     ctx;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;

  ent_t q  [DEPTH];
  ent_t nq [DEPTH];

  logic [ID_W:0]     cnt;
  logic [ID_W:0]     ncnt;
  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  surv;
  logic [ID_W-1:0]   sel;
  logic              found;
  logic              sel_kill;
  logic              iss_v;
  logic              fire;
  logic              enq_fire;
  logic              enq_keep;

  function automatic logic wake(
    input logic [PTAG_W-1:0]        t,
    input logic [NUM_WB-1:0]        wv,
    input logic [NUM_WB*PTAG_W-1:0] wt
  );
    logic h;
    h = 1'b0;
    for (int b = 0; b < NUM_WB; b++)
      if (wv[b] && wt[b*PTAG_W +: PTAG_W] == t)
        h = 1'b1;
    return h;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = q[i].vld & q[i].r1 & q[i].r2;
  end

  // Downward scan so the lowest (oldest) ready slot wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = SCAN - 1; i >= 0; i--)
      if (rdy[i]) begin
        sel   = ID_W'(i);
        found = 1'b1;
      end
  end

  assign sel_kill = io.flush & |(q[sel].ctx & io.flush_mask);
  assign iss_v    = found & ~sel_kill;
  assign fire     = iss_v & io.iss_accepted;

  assign io.iss_valid   = iss_v;
  assign io.iss_payload = iss_v ? q[sel].pl  : '0;
  assign io.iss_ctx     = iss_v ? q[sel].ctx : '0;
  assign io.count       = cnt;
  assign io.enq_ready   = (cnt < DEPTH_C) | fire;

  assign enq_fire = io.enq_valid & io.enq_ready;
  assign enq_keep = enq_fire &
                    ~(io.flush & |(io.enq_ctx & io.flush_mask));

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      surv[i] = q[i].vld
              & ~(io.flush & |(q[i].ctx & io.flush_mask))
              & ~(fire && sel == ID_W'(i));
  end

  always_comb begin
    logic [ID_W:0] k;
    k = '0;
    for (int i = 0; i < DEPTH; i++)
      nq[i] = '0;
    for (int i = 0; i < DEPTH; i++)
      if (surv[i]) begin
        nq[k[ID_W-1:0]] = q[i];
        k = k + 1'b1;
      end
    ncnt = k;
    // Room is guaranteed by enq_ready, so k < DEPTH here.
    if (enq_keep) begin
      nq[k[ID_W-1:0]].vld = 1'b1;
      nq[k[ID_W-1:0]].r1  = io.enq_rs1_rdy;
      nq[k[ID_W-1:0]].t1  = io.enq_rs1_tag;
      nq[k[ID_W-1:0]].r2  = io.enq_rs2_rdy;
      nq[k[ID_W-1:0]].t2  = io.enq_rs2_tag;
      nq[k[ID_W-1:0]].ctx = io.enq_ctx;
      nq[k[ID_W-1:0]].pl  = io.enq_payload;
      ncnt = k + 1'b1;
    end
    for (int i = 0; i < DEPTH; i++)
      if (nq[i].vld) begin
        if (wake(nq[i].t1, io.wb_valid, io.wb_tag))
          nq[i].r1 = 1'b1;
        if (wake(nq[i].t2, io.wb_valid, io.wb_tag))
          nq[i].r2 = 1'b1;
      end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else begin
      cnt <= ncnt;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= nq[i];
    end
  end

endmodule

// File: tb/tb_issue_window.sv
// Randomised scoreboard bench for issue_window against a
// queue-based reference model of the window rules.
module tb_issue_window;

  localparam int DEPTH = 8;
  localparam int SCAN  = 4;

  logic clk;
  logic rstn;

  issue_window_if #(
    .ID_W(3), .NUM_WB(2), .PTAG_W(6),
    .CTX_W(4), .PAYLOAD_W(64)
  ) bif ();

  issue_window #(
    .DEPTH(8), .ID_W(3), .SCAN(4), .NUM_WB(2),
    .PTAG_W(6), .CTX_W(4), .PAYLOAD_W(64)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        r1;
    bit [5:0]  t1;
    bit        r2;
    bit [5:0]  t2;
    bit [3:0]  ctx;
    bit [63:0] pl;
  } m_t;

  typedef struct {
    bit        iv;
    bit [63:0] pl;
    bit [3:0]  cx;
    int        cnt;
    bit        er;
  } e_t;

  m_t mq[$];
  e_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic bit mwake(bit [5:0] t, bit [1:0] wv,
                               bit [11:0] wt);
    for (int b = 0; b < 2; b++)
      if (wv[b] && wt[b*6 +: 6] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(
    input bit ev, input bit [5:0] t1, input bit r1,
    input bit [5:0] t2, input bit r2, input bit [3:0] cx,
    input bit [63:0] pl, input bit [1:0] wv,
    input bit [11:0] wt, input bit fl, input bit [3:0] fm,
    input bit acc
  );
    e_t e;
    m_t n;
    m_t nq[$];
    int sel;
    @(negedge clk);
    bif.enq_valid    = ev;
    bif.enq_rs1_tag  = t1;
    bif.enq_rs1_rdy  = r1;
    bif.enq_rs2_tag  = t2;
    bif.enq_rs2_rdy  = r2;
    bif.enq_ctx      = cx;
    bif.enq_payload  = pl;
    bif.wb_valid     = wv;
    bif.wb_tag       = wt;
    bif.flush        = fl;
    bif.flush_mask   = fm;
    bif.iss_accepted = acc;
    sel = -1;
    for (int i = 0; i < SCAN && i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) begin
        sel = i;
        break;
      end
    e.iv  = (sel >= 0) && !(fl && |(mq[sel].ctx & fm));
    e.pl  = e.iv ? mq[sel].pl  : 64'd0;
    e.cx  = e.iv ? mq[sel].ctx : 4'd0;
    e.cnt = mq.size();
    e.er  = (mq.size() < DEPTH) || (e.iv && acc);
    sb.push_back(e);
    for (int i = 0; i < mq.size(); i++)
      if (!(fl && |(mq[i].ctx & fm)) && !(e.iv && acc && i == sel))
        nq.push_back(mq[i]);
    if (ev && e.er && !(fl && |(cx & fm))) begin
      n.r1 = r1; n.t1 = t1; n.r2 = r2; n.t2 = t2;
      n.ctx = cx; n.pl = pl;
      nq.push_back(n);
    end
    for (int i = 0; i < nq.size(); i++) begin
      if (mwake(nq[i].t1, wv, wt)) nq[i].r1 = 1'b1;
      if (mwake(nq[i].t2, wv, wt)) nq[i].r2 = 1'b1;
    end
    mq = nq;
  endtask

  task automatic idle(input bit acc);
    step(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic put(input bit [63:0] pl, input bit [3:0] cx,
                     input bit r1, input bit acc);
    step(1, 6'd3, r1, 6'd4, 1, cx, pl, 0, 0, 0, 0, acc);
  endtask

  // Monitor: pop one expectation per cycle and compare.
  initial begin
    e_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        checks++;
        if (bif.iss_valid !== e.iv || bif.iss_payload !== e.pl ||
            bif.iss_ctx !== e.cx) begin
          failures++;
          $display("FAIL iss cyc=%0d got v=%b pl=%h cx=%h want v=%b pl=%h cx=%h",
                   cyc, bif.iss_valid, bif.iss_payload, bif.iss_ctx,
                   e.iv, e.pl, e.cx);
        end
        checks++;
        if (int'(bif.count) != e.cnt) begin
          failures++;
          $display("FAIL count cyc=%0d got %0d want %0d",
                   cyc, bif.count, e.cnt);
        end
        checks++;
        if (bif.enq_ready !== e.er) begin
          failures++;
          $display("FAIL enq_ready cyc=%0d got %b want %b",
                   cyc, bif.enq_ready, e.er);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bif.enq_valid = 0; bif.enq_rs1_tag = 0; bif.enq_rs1_rdy = 0;
    bif.enq_rs2_tag = 0; bif.enq_rs2_rdy = 0; bif.enq_ctx = 0;
    bif.enq_payload = 0; bif.wb_valid = 0; bif.wb_tag = 0;
    bif.flush = 0; bif.flush_mask = 0; bif.iss_accepted = 0;
    #1;
    checks++;
    if (bif.count !== 0 || bif.iss_valid !== 1'b0 ||
        bif.enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got cnt=%0d v=%b er=%b want 0 0 1",
               bif.count, bif.iss_valid, bif.enq_ready);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // in-order drain of three ready entries
    for (int i = 0; i < 3; i++) put(64'h100 + 64'(i), 1, 1, 0);
    repeat (4) idle(1);

    // older blocked entry, younger ready one bypasses it
    step(1, 6'd5, 0, 6'd1, 1, 1, 64'hA, 0, 0, 0, 0, 0);
    put(64'hB, 1, 1, 0);
    idle(1);
    step(0, 0, 1, 0, 1, 1, 0, 2'b01, 12'd5, 0, 0, 1);
    repeat (2) idle(1);

    // full window, issue frees a slot for a same-cycle enqueue
    put(64'h200, 1, 1, 0);
    for (int i = 1; i < DEPTH; i++) put(64'h200 + 64'(i), 1, 0, 0);
    put(64'h2FF, 1, 1, 1);
    step(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 4'hF, 1);
    idle(0);

    // context flush kills selected slot and a matching enqueue
    put(64'h301, 4'b0001, 1, 0);
    put(64'h302, 4'b0010, 1, 0);
    put(64'h303, 4'b0001, 1, 0);
    put(64'h304, 4'b0100, 1, 0);
    step(1, 0, 1, 0, 1, 4'b0001, 64'h3FF, 0, 0, 1, 4'b0001, 1);
    idle(0);
    repeat (3) idle(1);

    // wakeup in the enqueue cycle is not lost
    step(1, 6'd2, 1, 6'd9, 0, 1, 64'h400, 2'b10, 12'(9 << 6), 0, 0, 1);
    repeat (2) idle(1);

    // randomised traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0,
           6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           4'(1 << $urandom_range(0, 3)),
           {$urandom, $urandom},
           2'($urandom_range(0, 3)),
           {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
           $urandom_range(0, 19) == 0,
           4'($urandom_range(1, 15)),
           $urandom_range(0, 3) != 0);

    // stalled issue, then asynchronous reset between edges
    step(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 4'hF, 0);
    put(64'h500, 1, 1, 0);
    put(64'h501, 1, 1, 0);
    repeat (3) idle(0);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if (bif.count !== 0 || bif.iss_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got cnt=%0d v=%b want 0 0",
               bif.count, bif.iss_valid);
    end
    mq.delete();
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    put(64'h600, 1, 1, 0);
    repeat (2) idle(1);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
